// File: rtl/mmcm_drp_reconfig.sv
`default_nettype none
// ============================================================================
// mmcm_drp_reconfig - reprograms MMCM CLKOUT0/DIVCLK/CLKFBOUT through the DRP
// using read-modify-write cycles. Optional readback verify: MMCM_DRP_VERIFY_EN.
// Revision: 1.0
// ============================================================================
module mmcm_drp_reconfig (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_master_mul,
  input  logic [6:0]  cfg_master_div,
  input  logic [6:0]  cfg_clk_div,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0]  C_DRP_TMO_LAST  = 8'hFF;
  localparam logic [15:0] C_LOCK_TMO_LAST = 16'hFFFF;
  localparam logic [2:0]  C_LAST_REG      = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ASSERT_RST = 4'd1,
    S_RD         = 4'd2,
    S_RD_WAIT    = 4'd3,
    S_WR         = 4'd4,
    S_WR_WAIT    = 4'd5,
    S_RELEASE    = 4'd6,
    S_LOCK_WAIT  = 4'd7,
    S_DONE       = 4'd8
`ifdef MMCM_DRP_VERIFY_EN
    ,
    S_VRD        = 4'd9,
    S_VRD_WAIT   = 4'd10
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  mul_q, mul_d;
  logic [6:0]  mdiv_q, mdiv_d;
  logic [6:0]  cdiv_q, cdiv_d;
  logic [2:0]  idx_q, idx_d;
  logic [6:0]  daddr_q, daddr_d;
  logic [15:0] di_q, di_d;
  logic        err_q, err_d;
  logic [7:0]  drp_tmo_q, drp_tmo_d;
  logic [15:0] lock_tmo_q, lock_tmo_d;

  logic        cfg_legal;
  logic        drp_wait;
  logic        step_next;
  logic [15:0] reg_new;
  logic [15:0] reg_keep;

  // Divider field helpers: high=floor(d/2), low=d-high, edge=d[0], no_count=(d==1).
  // Only six bits of high/low exist in the MMCM, so low is formed modulo 64.
  function automatic logic [15:0] fn_r1(input logic [6:0] d);
    logic [5:0] hi;
    logic [5:0] lo;
    hi = d[6:1];
    lo = d[5:0] - hi;
    return {4'b0000, hi, lo};
  endfunction

  function automatic logic [15:0] fn_r2(input logic [6:0] d);
    return {8'h00, d[0], (d == 7'd1), 6'd0};
  endfunction

  function automatic logic [15:0] fn_divclk(input logic [6:0] d);
    logic [5:0] hi;
    logic [5:0] lo;
    hi = d[6:1];
    lo = d[5:0] - hi;
    return {2'b00, d[0], (d == 7'd1), hi, lo};
  endfunction

  function automatic logic [6:0] fn_addr(input logic [2:0] idx);
    logic [6:0] a;
    case (idx)
      3'd0:    a = 7'h08;
      3'd1:    a = 7'h09;
      3'd2:    a = 7'h16;
      3'd3:    a = 7'h14;
      default: a = 7'h15;
    endcase
    return a;
  endfunction

  assign cfg_legal = (cfg_master_mul >= 7'd2) && (cfg_master_mul <= 7'd64) &&
                     (cfg_master_div >= 7'd1) && (cfg_master_div <= 7'd106) &&
                     (cfg_clk_div    >= 7'd1) && (cfg_clk_div    <= 7'd126);

  always_comb begin
    reg_new  = 16'h0000;
    reg_keep = 16'h0000;
    case (idx_q)
      3'd0: begin
        reg_new  = fn_r1(cdiv_q);
        reg_keep = 16'h1000;
      end
      3'd1: begin
        reg_new  = fn_r2(cdiv_q);
        reg_keep = 16'hFF00;
      end
      3'd2: begin
        reg_new  = fn_divclk(mdiv_q);
        reg_keep = 16'hC000;
      end
      3'd3: begin
        reg_new  = fn_r1(mul_q);
        reg_keep = 16'h1000;
      end
      default: begin
        reg_new  = fn_r2(mul_q);
        reg_keep = 16'hFF00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mul_q      <= 7'd0;
      mdiv_q     <= 7'd0;
      cdiv_q     <= 7'd0;
      idx_q      <= 3'd0;
      daddr_q    <= 7'd0;
      di_q       <= 16'h0000;
      err_q      <= 1'b0;
      drp_tmo_q  <= 8'd0;
      lock_tmo_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      mul_q      <= mul_d;
      mdiv_q     <= mdiv_d;
      cdiv_q     <= cdiv_d;
      idx_q      <= idx_d;
      daddr_q    <= daddr_d;
      di_q       <= di_d;
      err_q      <= err_d;
      drp_tmo_q  <= drp_tmo_d;
      lock_tmo_q <= lock_tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mul_d      = mul_q;
    mdiv_d     = mdiv_q;
    cdiv_d     = cdiv_q;
    idx_d      = idx_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    err_d      = err_q;
    drp_tmo_d  = drp_tmo_q;
    lock_tmo_d = lock_tmo_q;
    drp_wait   = 1'b0;
    step_next  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          mul_d  = cfg_master_mul;
          mdiv_d = cfg_master_div;
          cdiv_d = cfg_clk_div;
          idx_d  = 3'd0;
          err_d  = !cfg_legal;
          state_d = cfg_legal ? S_ASSERT_RST : S_DONE;
        end
      end
      S_ASSERT_RST: begin
        daddr_d = fn_addr(idx_q);
        state_d = S_RD;
      end
      S_RD: begin
        drp_tmo_d = 8'd0;
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        drp_wait = 1'b1;
        if (drp_drdy) begin
          di_d    = (drp_do & reg_keep) | (reg_new & ~reg_keep);
          state_d = S_WR;
        end
      end
      S_WR: begin
        drp_tmo_d = 8'd0;
        state_d   = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        drp_wait = 1'b1;
        if (drp_drdy) begin
`ifdef MMCM_DRP_VERIFY_EN
          state_d = S_VRD;
`else
          step_next = 1'b1;
`endif
        end
      end
`ifdef MMCM_DRP_VERIFY_EN
      S_VRD: begin
        drp_tmo_d = 8'd0;
        state_d   = S_VRD_WAIT;
      end
      S_VRD_WAIT: begin
        drp_wait = 1'b1;
        if (drp_drdy) begin
          // A readback mismatch is recorded but the remaining registers still get written.
          if (drp_do != di_q) begin
            err_d = 1'b1;
          end
          step_next = 1'b1;
        end
      end
`endif
      S_RELEASE: begin
        lock_tmo_d = 16'd0;
        state_d    = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (mmcm_locked) begin
          state_d = S_DONE;
        end else if (lock_tmo_q == C_LOCK_TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          lock_tmo_d = lock_tmo_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (step_next) begin
      if (idx_q == C_LAST_REG) begin
        state_d = S_RELEASE;
      end else begin
        idx_d   = idx_q + 3'd1;
        daddr_d = fn_addr(idx_q + 3'd1);
        state_d = S_RD;
      end
    end

    // The 256th silent wait cycle after a den pulse aborts the sequence.
    if (drp_wait && !drp_drdy) begin
      if (drp_tmo_q == C_DRP_TMO_LAST) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        drp_tmo_d = drp_tmo_q + 8'd1;
      end
    end
  end

  always_comb begin
    mmcm_rst = 1'b0;
    case (state_q)
      S_ASSERT_RST, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT: mmcm_rst = 1'b1;
`ifdef MMCM_DRP_VERIFY_EN
      S_VRD, S_VRD_WAIT: mmcm_rst = 1'b1;
`endif
      default: mmcm_rst = 1'b0;
    endcase
  end

  always_comb begin
    drp_den = 1'b0;
    case (state_q)
      S_RD, S_WR: drp_den = 1'b1;
`ifdef MMCM_DRP_VERIFY_EN
      S_VRD: drp_den = 1'b1;
`endif
      default: drp_den = 1'b0;
    endcase
  end

  assign drp_dwe   = (state_q == S_WR);
  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign drp_daddr = daddr_q;
  assign drp_di    = di_q;

endmodule
`default_nettype wire
